// File: rtl/thread_register_file.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only (%blockIdx, %blockDim, %threadIdx).
// Optional write-protection error flag is built when REGFILE_PROT_CHECK_EN is defined.
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
`ifdef REGFILE_PROT_CHECK_EN
    ,
    output logic                 wr_prot_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_t;

    core_state_t state;
    assign state = core_state_t'(core_state);

    logic [DATA_BITS-1:0] regs [16];
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_legal;
    logic                 wr_illegal;

    always_comb begin
        wr_data = '0;
        case (decoded_reg_input_mux)
            2'b00:   wr_data = alu_out;
            2'b01:   wr_data = lsu_out;
            2'b10:   wr_data = decoded_immediate;
            default: wr_data = '0;
        endcase
    end

    // Writes to R13-R15 or through the reserved mux code are dropped.
    always_comb begin
        wr_legal   = decoded_reg_write_enable && (decoded_rd_address < 4'd13)
                     && (decoded_reg_input_mux != 2'b11);
        wr_illegal = decoded_reg_write_enable && ((decoded_rd_address >= 4'd13)
                     || (decoded_reg_input_mux == 2'b11));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 14; i++) begin
                regs[i] <= '0;
            end
            regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[15] <= DATA_BITS'(THREAD_ID);
            rs       <= '0;
            rt       <= '0;
        end else if (enable) begin
            // Reads sample the pre-edge R13, so a same-cycle block_id change is not seen.
            regs[13] <= DATA_BITS'(block_id);
            if (state == S_REQUEST) begin
                rs <= regs[decoded_rs_address];
                rt <= regs[decoded_rt_address];
            end
            if (state == S_UPDATE && wr_legal) begin
                regs[decoded_rd_address] <= wr_data;
            end
        end
    end

`ifdef REGFILE_PROT_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_prot_err <= 1'b0;
        end else if (enable && state == S_UPDATE && wr_illegal) begin
            wr_prot_err <= 1'b1;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = wr_illegal;
`endif

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file with a behavioural model checked every cycle.
// Built with or without REGFILE_PROT_CHECK_EN to match the design.
module tb_thread_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_WAIT    = 3'b100;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_a, rs_a, rt_a;
    logic       we;
    logic [1:0] mux;
    logic [7:0] imm, alu, lsu;
    logic [7:0] rs, rt;
    logic       err;

    int total = 0;
    int bad   = 0;

    thread_register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .block_id(block_id),
        .core_state(core_state),
        .decoded_rd_address(rd_a),
        .decoded_rs_address(rs_a),
        .decoded_rt_address(rt_a),
        .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux),
        .decoded_immediate(imm),
        .alu_out(alu),
        .lsu_out(lsu),
        .rs(rs),
        .rt(rt)
`ifdef REGFILE_PROT_CHECK_EN
        ,
        .wr_prot_err(err)
`endif
    );

`ifndef REGFILE_PROT_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural register contents and operand latches by the rules of the block.
    logic [7:0] m_reg [16];
    logic [7:0] m_rs, m_rt;
    logic       m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_reg[i]) m_reg[i] = 8'h00;
            m_reg[14] = 8'(TPB);
            m_reg[15] = 8'(TID);
            m_rs  = 8'h00;
            m_rt  = 8'h00;
            m_err = 1'b0;
        end else if (enable) begin
            if (core_state == ST_REQUEST) begin
                m_rs = m_reg[rs_a];
                m_rt = m_reg[rt_a];
            end
            if (core_state == ST_UPDATE && we) begin
                if (rd_a <= 4'd12 && mux != 2'b11)
                    m_reg[rd_a] = (mux == 2'b00) ? alu : (mux == 2'b01) ? lsu : imm;
                else
                    m_err = 1'b1;
            end
            m_reg[13] = block_id;
        end
    end

    always @(negedge clk) begin
        check("model_rs", rs, m_rs);
        check("model_rt", rt, m_rt);
`ifdef REGFILE_PROT_CHECK_EN
        check("model_err", {7'b0, err}, {7'b0, m_err});
`endif
    end

    // Drive one cycle's worth of inputs at the falling edge, then advance to the next falling edge.
    task automatic step(input logic [2:0] st, input logic [3:0] s_a, input logic [3:0] t_a,
                        input logic [3:0] d_a, input logic w, input logic [1:0] m,
                        input logic [7:0] value);
        core_state = st;
        rs_a = s_a;
        rt_a = t_a;
        rd_a = d_a;
        we   = w;
        mux  = m;
        imm  = value;
        alu  = value;
        lsu  = value;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; block_id = 8'h00; core_state = ST_IDLE;
        rd_a = 4'd0; rs_a = 4'd0; rt_a = 4'd0; we = 1'b0; mux = 2'b00;
        imm = 8'h00; alu = 8'h00; lsu = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_rs", rs, 8'h00);
        check("reset_rt", rt, 8'h00);
        check("reset_err", {7'b0, err}, 8'h00);
        reset_n = 1'b1;

        // Read-only registers and R0 after reset.
        step(ST_REQUEST, 4'd14, 4'd15, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r14_blockdim", rs, 8'h04);
        check("r15_threadidx", rt, 8'h02);
        step(ST_REQUEST, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r0_zero", rs, 8'h00);

        // Writes through each mux source.
        step(ST_UPDATE, 4'd0, 4'd0, 4'd3, 1'b1, 2'b00, 8'h5A);
        step(ST_REQUEST, 4'd3, 4'd3, 4'd0, 1'b0, 2'b00, 8'h00);
        check("alu_write_rs", rs, 8'h5A);
        check("alu_write_rt", rt, 8'h5A);
        step(ST_UPDATE, 4'd0, 4'd0, 4'd3, 1'b1, 2'b01, 8'hC3);
        step(ST_REQUEST, 4'd3, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("lsu_write", rs, 8'hC3);
        step(ST_UPDATE, 4'd0, 4'd0, 4'd3, 1'b1, 2'b10, 8'h7F);
        step(ST_REQUEST, 4'd3, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("imm_write", rs, 8'h7F);
        step(ST_UPDATE, 4'd0, 4'd0, 4'd12, 1'b1, 2'b10, 8'hA5);
        step(ST_REQUEST, 4'd12, 4'd3, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r12_write", rs, 8'hA5);
        check("r3_held", rt, 8'h7F);
        step(ST_UPDATE, 4'd0, 4'd0, 4'd6, 1'b0, 2'b10, 8'h44);
        step(ST_REQUEST, 4'd6, 4'd6, 4'd0, 1'b0, 2'b00, 8'h00);
        check("we0_no_write", rs, 8'h00);

        // Operands hold outside REQUEST even when addresses change.
        step(ST_WAIT, 4'd12, 4'd12, 4'd0, 1'b0, 2'b00, 8'h00);
        check("hold_wait", rs, 8'h00);

        // Protected destination and reserved mux.
        step(ST_UPDATE, 4'd0, 4'd0, 4'd14, 1'b1, 2'b10, 8'h99);
        step(ST_REQUEST, 4'd14, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r14_protected", rs, 8'h04);
`ifdef REGFILE_PROT_CHECK_EN
        check("err_set", {7'b0, err}, 8'h01);
`endif
        for (int i = 0; i < 10; i++) step(ST_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
`ifdef REGFILE_PROT_CHECK_EN
        check("err_sticky", {7'b0, err}, 8'h01);
`endif
        step(ST_UPDATE, 4'd0, 4'd0, 4'd4, 1'b1, 2'b11, 8'h33);
        step(ST_REQUEST, 4'd4, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("mux11_no_write", rs, 8'h00);

        // Inactive lane freezes registers and operands.
        enable = 1'b0;
        step(ST_UPDATE, 4'd0, 4'd0, 4'd1, 1'b1, 2'b00, 8'h11);
        enable = 1'b1;
        step(ST_REQUEST, 4'd1, 4'd3, 4'd0, 1'b0, 2'b00, 8'h00);
        check("disabled_write", rs, 8'h00);
        check("prior_rt", rt, 8'h7F);
        enable = 1'b0;
        step(ST_REQUEST, 4'd14, 4'd15, 4'd0, 1'b0, 2'b00, 8'h00);
        check("disabled_rs_hold", rs, 8'h00);
        check("disabled_rt_hold", rt, 8'h7F);
        enable = 1'b1;

        // R13 mirrors block_id; same-edge read sees the old value.
        block_id = 8'h07;
        step(ST_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        block_id = 8'h08;
        step(ST_REQUEST, 4'd13, 4'd13, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r13_old", rs, 8'h07);
        step(ST_REQUEST, 4'd13, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r13_new", rs, 8'h08);
        step(ST_UPDATE, 4'd0, 4'd0, 4'd13, 1'b1, 2'b10, 8'h55);
        step(ST_REQUEST, 4'd13, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r13_protected", rs, 8'h08);

        // Asynchronous reset in the middle of an UPDATE.
        step(ST_REQUEST, 4'd3, 4'd12, 4'd0, 1'b0, 2'b00, 8'h00);
        core_state = ST_UPDATE; rd_a = 4'd5; we = 1'b1; mux = 2'b00; alu = 8'hEE;
        #2 reset_n = 1'b0;
        #1;
        check("async_rs", rs, 8'h00);
        check("async_rt", rt, 8'h00);
        check("async_err", {7'b0, err}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step(ST_REQUEST, 4'd5, 4'd14, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r5_after_reset", rs, 8'h00);
        check("r14_restored", rt, 8'h04);
        step(ST_REQUEST, 4'd15, 4'd3, 4'd0, 1'b0, 2'b00, 8'h00);
        check("r15_restored", rs, 8'h02);
        check("r3_cleared", rt, 8'h00);

        step(ST_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
